mandel_dispatch_rob: RTL and testbench

- Next-generation pixel scheduler for the multi-engine Mandelbrot datapath.
- Hands pixel coordinates to NUM_ENGINES external depth engines, one start pulse per pixel.
- Collects depth results that finish out of order and re-emits them strictly in raster order through a reorder buffer (ROB), on a valid/ready output stream with backpressure.
- Supports single-line mode and whole-frame mode; sits between the depth engines and the framebuffer/BRAM writer.

---
 rtl/mandel_dispatch_rob.sv | 179 +++++++++++++++++
 tb/tb_mandel_dispatch_rob.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_dispatch_rob.sv
// rtl/mandel_dispatch_rob.sv - pixel dispatcher to N depth engines with raster-order reorder buffer
module mandel_dispatch_rob #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 4,
  parameter int DEPTH_W       = 10,
  parameter int ROB_DEPTH     = 16,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_start,
  input  logic                           i_frame_mode,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_ENGINES-1:0]         o_eng_start,
  output logic [NUM_ENGINES*XW-1:0]      o_eng_x,
  output logic [NUM_ENGINES*YW-1:0]      o_eng_y,
  input  logic [NUM_ENGINES-1:0]         i_eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] i_eng_depth,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [XW-1:0]                  o_out_x,
  output logic [YW-1:0]                  o_out_y,
  output logic [DEPTH_W-1:0]             o_out_depth,
  output logic                           o_out_eol,
  output logic                           o_out_eof
);
  localparam int AW = $clog2(ROB_DEPTH);
  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic                   r_busy, r_mode, r_pend, r_done;
  logic [YW-1:0]          r_ycur, r_dy;
  logic [XW-1:0]          r_dx;
  logic [AW:0]            r_head, r_tail;
  logic [NUM_ENGINES-1:0] r_eng_busy, r_eng_start;
  logic [AW-1:0]          r_eng_tag [NUM_ENGINES];
  logic [XW-1:0]          r_eng_x   [NUM_ENGINES];
  logic [YW-1:0]          r_eng_y   [NUM_ENGINES];
  logic [ROB_DEPTH-1:0]   r_slot_v;
  logic [DEPTH_W-1:0]     r_slot_d  [ROB_DEPTH];
  logic [XW-1:0]          r_slot_x  [ROB_DEPTH];
  logic [YW-1:0]          r_slot_y  [ROB_DEPTH];
  logic                   r_ov, r_oeol, r_oeof, r_olast;
  logic [XW-1:0]          r_ox;
  logic [YW-1:0]          r_oy;
  logic [DEPTH_W-1:0]     r_od;

  logic [AW:0]            w_occ;
  logic [AW-1:0]          w_head_idx;
  logic                   w_eng_avail, w_disp, w_disp_last;
  logic [EW-1:0]          w_eng_sel;
  logic                   w_byp, w_hd_v, w_load, w_hs, w_fin, w_ld_eol, w_ld_last;
  logic [DEPTH_W-1:0]     w_byp_d, w_hd_d;
  logic [XW-1:0]          w_byp_x, w_hd_x;
  logic [YW-1:0]          w_byp_y, w_hd_y;

  assign w_occ       = r_tail - r_head;
  assign w_head_idx  = r_head[AW-1:0];
  assign w_disp_last = (r_dx == XW'(SCREEN_WIDTH-1)) && (!r_mode || r_dy == YW'(SCREEN_HEIGHT-1));
  assign w_disp      = r_busy && r_pend && w_eng_avail && (w_occ < (AW+1)'(ROB_DEPTH));

  always_comb begin
    w_eng_avail = 1'b0;
    w_eng_sel   = '0;
    for (int i = NUM_ENGINES-1; i >= 0; i--) begin
      if (!r_eng_busy[i]) begin
        w_eng_avail = 1'b1;
        w_eng_sel   = EW'(i);
      end
    end
  end

  // A result landing in the head slot this cycle goes straight to the output register.
  always_comb begin
    w_byp   = 1'b0;
    w_byp_d = '0;
    w_byp_x = '0;
    w_byp_y = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (i_eng_done[i] && r_eng_busy[i] && r_eng_tag[i] == w_head_idx) begin
        w_byp   = 1'b1;
        w_byp_d = i_eng_depth[i*DEPTH_W +: DEPTH_W];
        w_byp_x = r_eng_x[i];
        w_byp_y = r_eng_y[i];
      end
    end
  end

  assign w_hd_v    = r_slot_v[w_head_idx] || w_byp;
  assign w_hd_d    = r_slot_v[w_head_idx] ? r_slot_d[w_head_idx] : w_byp_d;
  assign w_hd_x    = r_slot_v[w_head_idx] ? r_slot_x[w_head_idx] : w_byp_x;
  assign w_hd_y    = r_slot_v[w_head_idx] ? r_slot_y[w_head_idx] : w_byp_y;
  assign w_hs      = r_ov && i_out_ready;
  assign w_load    = w_hd_v && (!r_ov || i_out_ready);
  assign w_ld_eol  = (w_hd_x == XW'(SCREEN_WIDTH-1));
  assign w_ld_last = w_ld_eol && (!r_mode || w_hd_y == YW'(SCREEN_HEIGHT-1));
  assign w_fin     = w_hs && r_olast;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0; r_mode <= 1'b0; r_pend <= 1'b0; r_done <= 1'b0;
      r_ycur <= '0; r_dy <= '0; r_dx <= '0; r_head <= '0; r_tail <= '0;
      r_eng_busy <= '0; r_eng_start <= '0; r_slot_v <= '0;
      r_ov <= 1'b0; r_oeol <= 1'b0; r_oeof <= 1'b0; r_olast <= 1'b0;
      r_ox <= '0; r_oy <= '0; r_od <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_eng_tag[i] <= '0; r_eng_x[i] <= '0; r_eng_y[i] <= '0;
      end
    end else begin
      r_eng_start <= '0;
      r_done      <= w_fin;
      if (i_start && !r_busy) begin
        r_busy <= 1'b1; r_mode <= i_frame_mode; r_pend <= 1'b1;
        r_dx   <= '0;   r_dy   <= r_ycur;
      end
      if (w_fin) begin
        r_busy <= 1'b0;
        r_ycur <= (r_mode || r_ycur == YW'(SCREEN_HEIGHT-1)) ? '0 : r_ycur + 1'b1;
      end
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (i_eng_done[i] && r_eng_busy[i]) begin
          r_eng_busy[i]          <= 1'b0;
          r_slot_v[r_eng_tag[i]] <= 1'b1;
          r_slot_d[r_eng_tag[i]] <= i_eng_depth[i*DEPTH_W +: DEPTH_W];
          r_slot_x[r_eng_tag[i]] <= r_eng_x[i];
          r_slot_y[r_eng_tag[i]] <= r_eng_y[i];
        end
      end
      if (w_disp) begin
        r_eng_busy[w_eng_sel]  <= 1'b1;
        r_eng_start[w_eng_sel] <= 1'b1;
        r_eng_tag[w_eng_sel]   <= r_tail[AW-1:0];
        r_eng_x[w_eng_sel]     <= r_dx;
        r_eng_y[w_eng_sel]     <= r_dy;
        r_tail                 <= r_tail + 1'b1;
        if (w_disp_last) begin
          r_pend <= 1'b0;
        end else if (r_dx == XW'(SCREEN_WIDTH-1)) begin
          r_dx <= '0;
          r_dy <= r_dy + 1'b1;
        end else begin
          r_dx <= r_dx + 1'b1;
        end
      end
      // Clearing the head slot must win over a same-cycle write to it.
      if (w_load) begin
        r_ov    <= 1'b1;
        r_ox    <= w_hd_x; r_oy <= w_hd_y; r_od <= w_hd_d;
        r_oeol  <= w_ld_eol;
        r_olast <= w_ld_last;
        r_oeof  <= w_ld_last && r_mode;
        r_slot_v[w_head_idx] <= 1'b0;
        r_head  <= r_head + 1'b1;
      end else if (w_hs) begin
        r_ov <= 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENGINES; g++) begin : g_eng
      assign o_eng_x[g*XW +: XW] = r_eng_x[g];
      assign o_eng_y[g*YW +: YW] = r_eng_y[g];
    end
  endgenerate

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_eng_start = r_eng_start;
  assign o_out_valid = r_ov;
  assign o_out_x     = r_ox;
  assign o_out_y     = r_oy;
  assign o_out_depth = r_od;
  assign o_out_eol   = r_oeol;
  assign o_out_eof   = r_oeof;
endmodule

// File: tb/tb_mandel_dispatch_rob.sv
// tb/tb_mandel_dispatch_rob.sv - directed bench for mandel_dispatch_rob on an 8x4 screen
module tb_mandel_dispatch_rob;
  localparam int W = 8, H = 4, NE = 4, DW = 10, ROB = 16;
  localparam int XW = $clog2(W), YW = $clog2(H);

  logic clk, reset, i_start, i_frame_mode, o_busy, o_done;
  logic [NE-1:0] o_eng_start, i_eng_done;
  logic [NE*XW-1:0] o_eng_x;
  logic [NE*YW-1:0] o_eng_y;
  logic [NE*DW-1:0] i_eng_depth;
  logic o_out_valid, i_out_ready, o_out_eol, o_out_eof;
  logic [XW-1:0] o_out_x;
  logic [YW-1:0] o_out_y;
  logic [DW-1:0] o_out_depth;

  mandel_dispatch_rob #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_ENGINES(NE),
                        .DEPTH_W(DW), .ROB_DEPTH(ROB)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_frame_mode(i_frame_mode),
    .o_busy(o_busy), .o_done(o_done), .o_eng_start(o_eng_start), .o_eng_x(o_eng_x),
    .o_eng_y(o_eng_y), .i_eng_done(i_eng_done), .i_eng_depth(i_eng_depth),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_x(o_out_x),
    .o_out_y(o_out_y), .o_out_depth(o_out_depth), .o_out_eol(o_out_eol), .o_out_eof(o_out_eof));

  typedef struct {int x; int y; int d; bit eol; bit eof;} pix_t;
  pix_t q[$];
  int n_checks = 0, n_err = 0, rd = 0;
  int done_cnt = 0, disp = 0, acc = 0, occ = 0, max_occ = 0;
  bit hold = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dfn(input int x, input int y);
    return (x * 37 + y * 101 + 3) % 1024;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Engine model: rotating latency, optional hold to make results collide in one cycle.
  initial begin
    int ecnt[NE], ex[NE], ey[NE], nstart;
    bit epend[NE];
    int lat_tab[4];
    logic [NE-1:0] dv;
    logic [NE*DW-1:0] dep;
    lat_tab = '{40, 3, 17, 9};
    nstart = 0; dep = '0;
    for (int i = 0; i < NE; i++) begin ecnt[i] = 0; epend[i] = 0; ex[i] = 0; ey[i] = 0; end
    i_eng_done = '0; i_eng_depth = '0;
    forever begin
      @(posedge clk); #1;
      dv = '0;
      for (int i = 0; i < NE; i++) begin
        if (ecnt[i] > 0) ecnt[i]--;
        if (epend[i] && ecnt[i] == 0 && !hold) begin
          dv[i] = 1'b1;
          dep[i*DW +: DW] = DW'(dfn(ex[i], ey[i]));
          epend[i] = 0;
        end
        if (o_eng_start[i]) begin
          ecnt[i] = lat_tab[nstart % 4];
          nstart++;
          epend[i] = 1;
          ex[i] = int'(o_eng_x[i*XW +: XW]);
          ey[i] = int'(o_eng_y[i*YW +: YW]);
        end
      end
      i_eng_done = dv;
      i_eng_depth = dep;
    end
  end

  // Output monitor: records handshakes and tracks ROB occupancy from the outside.
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      if (reset) begin
        disp = 0; acc = 0; occ = 0;
      end else begin
        disp += $countones(o_eng_start);
        occ = disp - acc - int'(o_out_valid);
        if (occ > max_occ) max_occ = occ;
        if (o_out_valid && i_out_ready) begin
          p.x = int'(o_out_x); p.y = int'(o_out_y); p.d = int'(o_out_depth);
          p.eol = o_out_eol; p.eof = o_out_eof;
          q.push_back(p);
          acc++;
        end
        if (o_done) done_cnt++;
      end
    end
  end

  task automatic start_job(input bit fm);
    i_frame_mode = fm; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("busy_cleared", o_busy, 0);
  endtask

  task automatic check_job(input int y0, input int nlines, input bit fm);
    pix_t p;
    chk("pixel_count", q.size() - rd, nlines * W);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < W; x++) begin
        if (rd < q.size()) begin
          p = q[rd]; rd++;
          chk("out_x", p.x, x);
          chk("out_y", p.y, y0 + l);
          chk("out_depth", p.d, dfn(x, y0 + l));
          chk("out_eol", p.eol, (x == W - 1));
          chk("out_eof", p.eof, fm && (x == W - 1) && (l == nlines - 1));
        end
      end
    end
  endtask

  task automatic wait_pixels(input int n, input int budget);
    int c;
    c = 0;
    while (q.size() < rd + n && c < budget) begin @(posedge clk); c++; end
    #1;
    chk("pixels_arrived", (q.size() >= rd + n), 1);
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_frame_mode = 1'b0; i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_valid", o_out_valid, 0);
    chk("rst_eng_start", o_eng_start, 0);
    chk("rst_eng_x", o_eng_x, 0);
    reset = 1'b0;

    // Four line jobs walk y = 0..3; a frame-mode start mid-job must be ignored.
    for (int k = 0; k < 4; k++) begin
      start_job(1'b0);
      if (k == 1) begin
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid_job", o_busy, 1);
        i_frame_mode = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
      end
      wait_done(2000);
      check_job(k, 1, 1'b0);
    end

    // Frame job from y = 0 with a long output stall.
    start_job(1'b1);
    wait_pixels(5, 2000);
    i_out_ready = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("stall_no_dispatch", o_eng_start, 0);
    chk("stall_valid_held", o_out_valid, 1);
    chk("stall_rob_full", occ, ROB);
    i_out_ready = 1'b1;
    wait_done(4000);
    check_job(0, H, 1'b1);
    chk("max_occupancy", max_occ, ROB);

    // All four engines finish in the same cycle.
    hold = 1'b1;
    start_job(1'b0);
    repeat (50) @(posedge clk);
    #1;
    chk("hold_no_dispatch", o_eng_start, 0);
    chk("hold_no_valid", o_out_valid, 0);
    hold = 1'b0;
    wait_done(2000);
    check_job(0, 1, 1'b0);

    // Reset in the middle of a frame job (lines 1..3).
    start_job(1'b1);
    wait_pixels(10, 2000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_out_valid, 0);
    chk("midrst_eng_start", o_eng_start, 0);
    chk("midrst_out_x", o_out_x, 0);
    chk("midrst_out_y", o_out_y, 0);
    chk("midrst_depth", o_out_depth, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd = q.size();
    repeat (80) @(posedge clk);
    #1;
    chk("late_done_ignored", q.size() - rd, 0);
    chk("late_valid_low", o_out_valid, 0);
    chk("late_busy_low", o_busy, 0);
    start_job(1'b0);
    wait_done(2000);
    check_job(0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
